// File: rtl/mvm_pkg.sv
// Shared types, constants and saturating arithmetic for the 4-lane stochastic MVM path.
package mvm_pkg;

  localparam int LANES     = 4;
  localparam int X_W       = 4;
  localparam int ACC_MAX_W = 32;

  typedef logic signed [X_W-1:0] lane_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAITB,
    S_RUN,
    S_OUT
  } sched_state_e;

  typedef struct packed {
    logic                        clip;
    logic signed [ACC_MAX_W-1:0] sum;
  } sat_res_t;

  // acc_w is the real accumulator width; acc must already be sign-extended to ACC_MAX_W
  function automatic sat_res_t sat_add(input logic signed [ACC_MAX_W-1:0] acc,
                                       input lane_t x, input int acc_w);
    logic signed [ACC_MAX_W+1:0] s;
    logic signed [ACC_MAX_W+1:0] hi;
    logic signed [ACC_MAX_W+1:0] lo;
    sat_res_t r;
    s  = {{2{acc[ACC_MAX_W-1]}}, acc} + {{(ACC_MAX_W+2-X_W){x[X_W-1]}}, x};
    hi = (ACC_MAX_W+2)'((64'd1 << (acc_w - 1)) - 64'd1);
    lo = ~hi;
    r.clip = 1'b0;
    r.sum  = s[ACC_MAX_W-1:0];
    if (s > hi) begin
      r.clip = 1'b1;
      r.sum  = hi[ACC_MAX_W-1:0];
    end else if (s < lo) begin
      r.clip = 1'b1;
      r.sum  = lo[ACC_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mvm_lane_acc.sv
// Single-lane signed saturating accumulator with synchronous clear and sticky clip flag.
module mvm_lane_acc
  import mvm_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [X_W-1:0]   din,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);

  sat_res_t res;
  logic     unused_hi;

  always_comb res = sat_add({{(ACC_MAX_W-ACC_W){acc[ACC_W-1]}}, acc}, lane_t'(din), ACC_W);

  // saturated result always fits ACC_W, so the upper bits are pure sign extension
  assign unused_hi = ^res.sum[ACC_MAX_W-1:ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= res.sum[ACC_W-1:0];
      sat <= sat | res.clip;
    end
  end

endmodule

// File: rtl/mvm_tile_sched.sv
// Tile sequencer: feeds x/w tiles to the MVM, accumulates lane results, emits per-lane sums.
// Optional busy-rise timeout is built when MVM_TILE_SCHED_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a job request
// LOAD    | ready for the next tile
// START   | one-cycle start pulse to the MVM
// WAITB   | waiting for MVM busy to rise
// RUN     | MVM busy; accumulate on the first not-busy cycle
// OUT     | sums presented until consumer accepts
module mvm_tile_sched
  import mvm_pkg::*;
#(
  parameter int ACC_W  = 8,
  parameter int LEN_W  = 6,
  parameter int TO_CYC = 16
) (
  input  logic                   i_clk_sched,
  input  logic                   i_rst_n_sched,
  input  logic                   i_job_start,
  input  logic [LEN_W-1:0]       i_job_len,
  output logic                   o_job_busy,
  input  logic                   i_tile_valid,
  output logic                   o_tile_ready,
  input  logic [LANES*X_W-1:0]   i_tile_x,
  input  logic [X_W-1:0]         i_tile_w,
  output logic                   o_mvm_start,
  output logic [LANES*X_W-1:0]   o_mvm_x,
  output logic [X_W-1:0]         o_mvm_w,
  input  logic                   i_mvm_busy,
  input  logic [LANES*X_W-1:0]   i_mvm_result,
  output logic                   o_y_valid,
  input  logic                   i_y_ready,
  output logic [LANES*ACC_W-1:0] o_y,
  output logic                   o_sat,
  output logic                   o_err
);

  if (ACC_W < X_W || ACC_W >= ACC_MAX_W || TO_CYC < 1) begin : g_param_chk
    $error("mvm_tile_sched: ACC_W must be in [4,31] and TO_CYC >= 1");
  end

  sched_state_e     state, state_nxt;
  logic [LEN_W-1:0] remain;
  logic             take_job, take_tile, acc_en, to_hit;
  logic [LANES-1:0] lane_sat;

  assign take_job  = (state == S_IDLE) && i_job_start;
  assign take_tile = (state == S_LOAD) && i_tile_valid;
  // MVM counters still hold the final value in the first not-busy cycle
  assign acc_en    = (state == S_RUN) && !i_mvm_busy;

`ifdef MVM_TILE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = (state == S_WAITB) && !i_mvm_busy && (to_cnt == '0);
  assign o_err  = err_q;

  always_ff @(posedge i_clk_sched or negedge i_rst_n_sched) begin
    if (!i_rst_n_sched) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_START) to_cnt <= TO_W'(TO_CYC - 1);
      else if (state == S_WAITB && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
      if (take_job) err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign o_err  = 1'b0;
`endif

  always_ff @(posedge i_clk_sched or negedge i_rst_n_sched) begin
    if (!i_rst_n_sched) begin
      state   <= S_IDLE;
      remain  <= '0;
      o_mvm_x <= '0;
      o_mvm_w <= '0;
    end else begin
      state <= state_nxt;
      if (take_job) remain <= i_job_len;
      else if (take_tile) remain <= remain - 1'b1;
      if (take_tile) begin
        o_mvm_x <= i_tile_x;
        o_mvm_w <= i_tile_w;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_job_start) state_nxt = (i_job_len == '0) ? S_OUT : S_LOAD;
      S_LOAD:  if (i_tile_valid) state_nxt = S_START;
      S_START: state_nxt = S_WAITB;
      S_WAITB: begin
        if (i_mvm_busy) state_nxt = S_RUN;
        else if (to_hit) state_nxt = S_OUT;
      end
      S_RUN:   if (!i_mvm_busy) state_nxt = (remain != '0) ? S_LOAD : S_OUT;
      S_OUT:   if (i_y_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_job_busy   = (state != S_IDLE);
  assign o_tile_ready = (state == S_LOAD);
  assign o_mvm_start  = (state == S_START);
  assign o_y_valid    = (state == S_OUT);
  assign o_sat        = |lane_sat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mvm_lane_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (i_clk_sched),
      .rst_n (i_rst_n_sched),
      .clr   (take_job),
      .en    (acc_en),
      .din   (i_mvm_result[g*X_W +: X_W]),
      .acc   (o_y[g*ACC_W +: ACC_W]),
      .sat   (lane_sat[g])
    );
  end

endmodule

// File: tb/tb_mvm_tile_sched.sv
// Scoreboard bench for mvm_tile_sched with a behavioural MVM stub (busy length and results programmable).
module tb_mvm_tile_sched;

  localparam int ACC_W  = 8;
  localparam int LEN_W  = 6;
  localparam int TO_CYC = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             job_start;
  logic [LEN_W-1:0] job_len;
  logic             job_busy;
  logic             tile_valid;
  logic             tile_ready;
  logic [15:0]      tile_x;
  logic [3:0]       tile_w;
  logic             mvm_start;
  logic [15:0]      mvm_x;
  logic [3:0]       mvm_w;
  logic             mvm_busy;
  logic [15:0]      mvm_result;
  logic             y_valid;
  logic             y_ready;
  logic [31:0]      y;
  logic             sat;
  logic             err;

  mvm_tile_sched #(.ACC_W(ACC_W), .LEN_W(LEN_W), .TO_CYC(TO_CYC)) dut (
    .i_clk_sched   (clk),
    .i_rst_n_sched (rst_n),
    .i_job_start   (job_start),
    .i_job_len     (job_len),
    .o_job_busy    (job_busy),
    .i_tile_valid  (tile_valid),
    .o_tile_ready  (tile_ready),
    .i_tile_x      (tile_x),
    .i_tile_w      (tile_w),
    .o_mvm_start   (mvm_start),
    .o_mvm_x       (mvm_x),
    .o_mvm_w       (mvm_w),
    .i_mvm_busy    (mvm_busy),
    .i_mvm_result  (mvm_result),
    .o_y_valid     (y_valid),
    .i_y_ready     (y_ready),
    .o_y           (y),
    .o_sat         (sat),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        sat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          n_start = 0;
  int          n_hs = 0;
  int          n_valid = 0;
  logic        stub_never = 1'b0;
  int          stub_busy_len = 5;
  logic [15:0] stub_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] ey, input logic es, input logic ee);
    exp_t e;
    e.y = ey; e.sat = es; e.err = ee;
    sb.push_back(e);
  endtask

  task automatic start_job(input int len);
    step();
    job_len   = LEN_W'(len);
    job_start = 1'b1;
    step();
    job_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (job_busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, job_busy, 1'b0);
  endtask

  task automatic run_job(input int len, input logic [15:0] res, input int blen,
                         input logic [31:0] ey, input logic es, input string tag);
    stub_res      = res;
    stub_busy_len = blen;
    push_exp(ey, es, 1'b0);
    start_job(len);
    wait_idle(tag);
    chk({tag, "_y_after"}, y, ey);
  endtask

  // event counters
  always @(negedge clk) begin
    if (rst_n) begin
      if (mvm_start) n_start++;
      if (tile_ready && tile_valid) n_hs++;
      if (y_valid) n_valid++;
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected none", y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_y", y, e.y);
        chk("out_sat", sat, e.sat);
        chk("out_err", err, e.err);
      end
    end
  end

  // behavioural MVM: busy rises one cycle after start, results valid through the first idle cycle
  always begin
    @(negedge clk);
    if (rst_n && mvm_start && !stub_never) begin
      chk("mvm_x", mvm_x, tile_x);
      chk("mvm_w", mvm_w, tile_w);
      @(negedge clk);
      mvm_busy   = 1'b1;
      mvm_result = stub_res;
      repeat (stub_busy_len) @(negedge clk);
      mvm_busy = 1'b0;
      @(negedge clk);
      mvm_result = 16'h5555;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_start, b_hs, k;
    rst_n      = 1'b0;
    job_start  = 1'b0;
    job_len    = '0;
    tile_valid = 1'b1;
    tile_x     = 16'h1234;
    tile_w     = 4'h5;
    mvm_busy   = 1'b0;
    mvm_result = '0;
    y_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {job_busy, tile_ready, mvm_start, y_valid, sat, err}, 6'b0);
    chk("rst_y", y, 32'h0);
    chk("rst_mvm_xw", {mvm_x, mvm_w}, 20'h0);
    step();
    rst_n = 1'b1;

    // single tile
    b_start = n_start; b_hs = n_hs; n_valid = 0;
    run_job(1, 16'h87E3, 5, pack4(3, -2, 7, -8), 1'b0, "single");
    chk("single_starts", n_start - b_start, 1);
    chk("single_hs", n_hs - b_hs, 1);
    chk("single_valid_cycles", n_valid, 1);

    // accumulation over three tiles
    tile_x = 16'hA5C3; tile_w = 4'h9;
    b_start = n_start; b_hs = n_hs;
    run_job(3, 16'h02F1, 3, pack4(3, -3, 6, 0), 1'b0, "accum");
    chk("accum_starts", n_start - b_start, 3);
    chk("accum_hs", n_hs - b_hs, 3);

    // lane0 saturates at +127, others exact
    tile_x = 16'h0F0F; tile_w = 4'hC;
    run_job(20, 16'h2F17, 2, pack4(127, 20, -20, 40), 1'b1, "sat");

    // zero-length job
    b_start = n_start;
    push_exp(32'h0, 1'b0, 1'b0);
    start_job(0);
    @(negedge clk);
    chk("len0_valid", y_valid, 1'b1);
    chk("len0_y", y, 32'h0);
    wait_idle("len0");
    chk("len0_starts", n_start - b_start, 0);

    // backpressure on output: sums stable, job start ignored
    y_ready = 1'b0;
    stub_res = 16'h5D04; stub_busy_len = 4;
    push_exp(pack4(4, 0, -3, 5), 1'b0, 1'b0);
    start_job(1);
    k = 0;
    while (!y_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("hold_reach_out", y_valid, 1'b1);
    b_start = n_start;
    for (int i = 0; i < 10; i++) begin
      step();
      job_start = (i == 3);
      job_len   = 6'd2;
      @(negedge clk);
      chk("hold_y", y, pack4(4, 0, -3, 5));
      chk("hold_valid", y_valid, 1'b1);
    end
    step();
    job_start = 1'b0;
    y_ready   = 1'b1;
    wait_idle("hold");
    repeat (4) @(negedge clk);
    chk("hold_no_restart", job_busy, 1'b0);
    chk("hold_starts", n_start - b_start, 0);

    // reset during RUN of tile 2
    stub_res = 16'h1111; stub_busy_len = 6;
    n_valid = 0;
    b_start = n_start;
    start_job(3);
    k = 0;
    while (!(n_start - b_start == 2 && mvm_busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_reach_run", mvm_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_ctrl", {job_busy, tile_ready, mvm_start, y_valid, sat, err}, 6'b0);
    chk("rstmid_y", y, 32'h0);
    chk("rstmid_mvm_xw", {mvm_x, mvm_w}, 20'h0);
    repeat (12) @(negedge clk);
    step();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", {job_busy, tile_ready, y_valid}, 3'b0);
    chk("rstmid_no_output", n_valid, 0);

    // tile input stalled in LOAD
    tile_valid = 1'b0;
    stub_res = 16'h2222; stub_busy_len = 3;
    b_start = n_start; b_hs = n_hs;
    push_exp(pack4(4, 4, 4, 4), 1'b0, 1'b0);
    start_job(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", tile_ready, 1'b1);
    end
    chk("bp_no_start", n_start - b_start, 0);
    step();
    tile_x = 16'h7E81; tile_w = 4'h3;
    tile_valid = 1'b1;
    wait_idle("bp");
    chk("bp_starts", n_start - b_start, 2);
    chk("bp_hs", n_hs - b_hs, 2);

`ifdef MVM_TILE_SCHED_TIMEOUT_EN
    stub_never = 1'b1;
    push_exp(32'h0, 1'b0, 1'b1);
    start_job(1);
    k = 0;
    while (!mvm_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_start_seen", mvm_start, 1'b1);
    repeat (16) @(negedge clk);
    chk("to_err_early", err, 1'b0);
    @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_valid", y_valid, 1'b1);
    wait_idle("to");
    stub_never = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvm_tile_sched.md
Name: mvm_tile_sched

Overview:
- Sequencer for the 4-lane stochastic MVM datapath (4 x-values times one weight, 4-bit results).
- Accepts a job of N tiles, each tile being one 4-lane x vector and one weight.
- Feeds each tile to the MVM, waits for its busy window to finish, and captures the 4 results.
- Accumulates the results into wide signed per-lane sums, then presents the 4 sums on a valid/ready output. Sits between the tile buffer and the post-MVM activation stage.

Parameters:
- ACC_W, 8, accumulator/output width per lane, signed, must be >= 4
- LEN_W, 6, width of job tile count
- TO_CYC, 16, cycles allowed from o_mvm_start until i_mvm_busy rises (timeout feature only)

Ports:
- i_clk_sched  in  1  single clock, all logic on rising edge
- i_rst_n_sched  in  1  asynchronous, active-low reset
- i_job_start  in  1  single-cycle job request, honoured in IDLE only
- i_job_len  in  LEN_W  tile count, sampled with i_job_start
- o_job_busy  out  1  high from job acceptance until the output handshake completes
- i_tile_valid  in  1  tile available
- o_tile_ready  out  1  scheduler can take a tile
- i_tile_x  in  4x4  tile x lanes, 4-bit signed
- i_tile_w  in  4  tile weight
- o_mvm_start  out  1  single-cycle start to MVM
- o_mvm_x  out  4x4  registered x lanes, held for the whole run
- o_mvm_w  out  4  registered weight, held for the whole run
- i_mvm_busy  in  1  MVM generating (o_ismvm)
- i_mvm_result  in  4x4  MVM lane results, 4-bit signed
- o_y_valid  out  1  sums valid
- i_y_ready  in  1  consumer accepts
- o_y  out  4xACC_W  per-lane signed sums
- o_sat  out  1  at least one lane saturated during this job
- o_err  out  1  timeout flag (timeout feature only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0, accumulators 0, state IDLE. Reset mid-job aborts immediately, with no output emitted.
- States: IDLE, LOAD, START, WAITB, RUN, OUT.
- IDLE:
  - On i_job_start: latch len, clear accumulators and o_sat, assert o_job_busy next cycle.
  - If len != 0, go to LOAD; if len == 0, go to OUT directly with all sums 0.
  - i_job_start outside IDLE is ignored.
- LOAD:
  - o_tile_ready = 1.
  - On i_tile_valid & o_tile_ready: register x and w onto o_mvm_x/o_mvm_w, decrement the remaining count, go to START.
  - o_tile_ready is 0 in every other state.
- START: o_mvm_start = 1 for exactly this cycle, then go to WAITB.
- WAITB: remain until i_mvm_busy == 1, then go to RUN.
- RUN:
  - Remain while i_mvm_busy == 1.
  - In the first cycle i_mvm_busy is sampled 0, capture i_mvm_result, because the MVM counters still hold their final value that cycle and clear on the next.
  - In that same cycle, accumulate each lane: sign-extend the 4-bit result to ACC_W and add with saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clipped lane sets o_sat (sticky until the next job).
  - Next state: LOAD if tiles remain, else OUT.
- OUT:
  - o_y_valid = 1, o_y holds the sums stable.
  - On i_y_ready, go to IDLE; o_y_valid and o_job_busy drop the next cycle. o_y keeps its value until the next job start.
- Per-tile minimum latency from tile handshake to accumulate: 3 + B cycles, where B is the busy length.
- A new tile is not accepted until the previous one has been accumulated (no overlap).
- o_mvm_x/o_mvm_w change only on a tile handshake.

Optional Feature:
- Macro: MVM_TILE_SCHED_TIMEOUT_EN
- Defined:
  - A counter runs in WAITB. If i_mvm_busy has not risen within TO_CYC cycles after START, set o_err (sticky until reset or next job start) and go to OUT with the partial sums.
  - The counter clears on every START.
- Undefined: no counter is built, o_err = 0, and WAITB waits indefinitely.

Decomposition:
- Shared package mvm_pkg holds:
  - state enum sched_state_e
  - LANES = 4 and X_W = 4 constants
  - typedef lane_t (4-bit signed)
  - the saturating sign-extend-add function, also used by the later bias stage
- One sub-module: mvm_lane_acc, a single-lane saturating accumulator with clear, enable and sat outputs, instantiated 4 times.

Test Plan:
- Bench uses a behavioural MVM stub with programmable busy length and results.
- Single tile: len=1, stub busy length 5, results {3,-2,7,-8}, i_y_ready=1 -> o_mvm_start pulses once; o_y={3,-2,7,-8}; o_sat=0; o_y_valid high for 1 cycle.
- Accumulation: len=3, each tile results {1,-1,2,0} -> o_y={3,-3,6,0}; exactly 3 tile handshakes and 3 start pulses.
- Saturation: ACC_W=8, len=20, lane0 result 7 every tile -> o_y[0]=127, o_sat=1, other lanes exact.
- Boundaries:
  - len=0 -> no start pulse, o_y=0, o_y_valid within 2 cycles.
  - With o_y_valid held and i_y_ready=0 for 10 cycles, o_y is stable and i_job_start is ignored.
- Reset and backpressure:
  - Assert i_rst_n_sched=0 during RUN of tile 2 -> all outputs 0 asynchronously, IDLE after release.
  - Deassert i_tile_valid for 4 cycles in LOAD -> no start pulse until the handshake.
- Timeout (macro defined, TO_CYC=16): stub never raises busy -> o_err=1 at cycle 17 after start; o_y_valid asserts with the prior sums.
